// File: rtl/timer_arbiter_pkg.sv
// timer_arbiter_pkg
// Shared types and default sizing for the timer arbiter.
//   state_t      : FSM state encoding (IDLE, RUN, DONE)
//   DEF_NUM_REQ  : default number of requesters
//   DEF_WIDTH    : default period/count width
package timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 32;

endpackage

// File: rtl/timer_core.sv
// timer_core
// Shared up-counter with terminal-count detect.
//   clk_in   : clock
//   rst_in   : async active-high reset
//   clear    : force count to 0 (wins over enable)
//   enable   : increment count by 1
//   period   : latched period of the current run
//   count    : current count (registered)
//   terminal : count == period-1, or constant 1 when period <= 1
module timer_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    // Periods 0 and 1 both mean a single cycle; the subtraction is only
    // evaluated for period >= 2 so it can never wrap.
    always_comb begin
        if (period <= WIDTH'(1)) begin
            terminal = 1'b1;
        end else begin
            terminal = (count_q == (period - WIDTH'(1)));
        end
    end

    assign count = count_q;

endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter
// Grants one shared timer to one of NUM_REQ requesters at a time.
// Optional macro: TIMER_ARBITER_ROUND_ROBIN_EN selects round-robin
// arbitration; when undefined, lowest index wins (fixed priority).
//   clk_in    : clock
//   rst_in    : async active-high reset
//   req_in    : per-requester request level
//   period_in : period of requester i in [i*WIDTH +: WIDTH]
//   grant_out : one-hot owner of the counter, else zero
//   done_out  : one-hot one-cycle completion pulse
//   busy_out  : high whenever the FSM is not IDLE
//   count_out : shared counter value
//
// state | meaning
// IDLE  | no owner; arbitrate among active requests
// RUN   | owner counting 0 .. period-1; abort if owner drops req
// DONE  | one-cycle completion pulse, then back to IDLE
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_in,
    input  logic [NUM_REQ*WIDTH-1:0] period_in,
    output logic [NUM_REQ-1:0]       grant_out,
    output logic [NUM_REQ-1:0]       done_out,
    output logic                     busy_out,
    output logic [WIDTH-1:0]         count_out
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   period_q, period_d;

    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic               any_req;
    logic               core_clear;
    logic               core_enable;
    logic               core_terminal;

`ifdef TIMER_ARBITER_ROUND_ROBIN_EN
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               found;

    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_in[(int'(ptr_q) + i) % NUM_REQ]) begin
                found   = 1'b1;
                win_idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_in[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end
`endif

    assign any_req = |req_in;
    assign win_oh  = NUM_REQ'(1) << win_idx;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        busy_d      = busy_q;
        period_d    = period_q;
        core_clear  = 1'b1;
        core_enable = 1'b0;
`ifdef TIMER_ARBITER_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = RUN;
                    grant_d  = win_oh;
                    busy_d   = 1'b1;
                    period_d = period_in[int'(win_idx)*WIDTH +: WIDTH];
`ifdef TIMER_ARBITER_ROUND_ROBIN_EN
                    ptr_d    = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
`endif
                end
            end
            RUN: begin
                core_clear  = 1'b0;
                core_enable = 1'b1;
                // Abort wins over a coincident terminal count: no done pulse
                // for a requester that has already withdrawn.
                if ((req_in & grant_q) == '0) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    busy_d     = 1'b0;
                    core_clear = 1'b1;
                end else if (core_terminal) begin
                    state_d    = DONE;
                    done_d     = grant_q;
                    core_clear = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            period_q <= '0;
`ifdef TIMER_ARBITER_ROUND_ROBIN_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            period_q <= period_d;
`ifdef TIMER_ARBITER_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    timer_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clear   (core_clear),
        .enable  (core_enable),
        .period  (period_q),
        .count   (count_out),
        .terminal(core_terminal)
    );

    assign grant_out = grant_q;
    assign done_out  = done_q;
    assign busy_out  = busy_q;

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic [N-1:0]   req_in;
    logic [N*W-1:0] period_in;
    logic [N-1:0]   grant_out;
    logic [N-1:0]   done_out;
    logic           busy_out;
    logic [W-1:0]   count_out;

    timer_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .req_in   (req_in),
        .period_in(period_in),
        .grant_out(grant_out),
        .done_out (done_out),
        .busy_out (busy_out),
        .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: who owns the timer, how long the run
    // lasts, how far it has progressed, and whether the completion pulse
    // is being shown.
    int m_owner;
    int m_len;
    int m_elapsed;
    int m_ptr;
    bit m_in_done;

    function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef TIMER_ARBITER_ROUND_ROBIN_EN
        for (int i = 0; i < N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
`else
        for (int i = 0; i < N; i++) if (r[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_len = 0; m_elapsed = 0; m_ptr = 0; m_in_done = 0;
    endtask

    task automatic model_edge();
        int w;
        int p;
        if (m_owner < 0) begin
            if (req_in != '0) begin
                w = pick(req_in, m_ptr);
                p = int'(period_in[w*W +: W]);
                m_owner = w;
                m_len = (p > 1) ? p : 1;
                m_elapsed = 0;
                m_in_done = 0;
                m_ptr = (w + 1) % N;
            end
        end else if (m_in_done) begin
            m_owner = -1;
            m_in_done = 0;
        end else if (!req_in[m_owner]) begin
            m_owner = -1;
            m_elapsed = 0;
        end else if (m_elapsed + 1 >= m_len) begin
            m_in_done = 1;
            m_elapsed = 0;
        end else begin
            m_elapsed++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] oh;
        oh = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk({tag, "_grant"}, 64'(grant_out), 64'(oh));
        chk({tag, "_done"},  64'(done_out),  64'(m_in_done ? oh : '0));
        chk({tag, "_busy"},  64'(busy_out),  64'(m_owner >= 0));
        chk({tag, "_count"}, 64'(count_out),
            64'((m_owner >= 0 && !m_in_done) ? m_elapsed : 0));
    endtask

    // One clock: model advances with the inputs seen at the edge; outputs
    // are checked on the following falling edge.
    task automatic cycle(input string tag);
        @(posedge clk_in);
        if (rst_in) model_reset();
        else model_edge();
        @(negedge clk_in);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        req_in = '0;
        cycle("rst");
        chk("rst_grant", 64'(grant_out), 64'(0));
        chk("rst_count", 64'(count_out), 64'(0));
        rst_in = 1'b0;
    endtask

    task automatic set_period(input int i, input int p);
        period_in[i*W +: W] = W'(p);
    endtask

    logic [N-1:0] gq[$];
    logic [N-1:0] prev_g;
    logic [N-1:0] exp_rr[5];

    initial begin
        rst_in = 1'b1;
        req_in = '0;
        period_in = '0;
        model_reset();
        @(negedge clk_in);
        do_reset();

        // Single request, period 5
        set_period(0, 5);
        req_in = 4'b0001;
        cycle("s030");
        chk("s030_grant", 64'(grant_out), 64'h1);
        for (int k = 0; k < 5; k++) begin
            chk("s030_cnt", 64'(count_out), 64'(k));
            cycle("s030");
        end
        chk("s030_done", 64'(done_out), 64'h1);
        req_in = '0;
        cycle("s030");
        chk("s030_idle", 64'(busy_out), 64'h0);
        chk("s030_done_off", 64'(done_out), 64'h0);

        // Period 0 and 1
        for (int p = 0; p < 2; p++) begin
            set_period(0, p);
            req_in = 4'b0001;
            cycle("s031");
            chk("s031_cnt", 64'(count_out), 64'h0);
            chk("s031_busy", 64'(busy_out), 64'h1);
            cycle("s031");
            chk("s031_done", 64'(done_out), 64'h1);
            req_in = '0;
            cycle("s031");
        end

        // Contention
        do_reset();
        for (int i = 0; i < N; i++) set_period(i, 3);
        req_in = 4'b1111;
        gq.delete();
        prev_g = '0;
        for (int c = 0; c < 30; c++) begin
            cycle("s032");
            if (grant_out != '0 && prev_g == '0) gq.push_back(grant_out);
            prev_g = grant_out;
        end
        req_in = '0;
        cycle("s032");
`ifdef TIMER_ARBITER_ROUND_ROBIN_EN
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
`else
        for (int i = 0; i < 5; i++) exp_rr[i] = 4'b0001;
`endif
        chk("s032_ngrants", 64'(gq.size() >= 5), 64'h1);
        for (int i = 0; i < 5; i++)
            chk("s032_order", 64'((i < gq.size()) ? gq[i] : '0), 64'(exp_rr[i]));

        // Abort at count 2 of period 10
        do_reset();
        set_period(0, 10);
        req_in = 4'b0001;
        cycle("s033"); cycle("s033"); cycle("s033");
        chk("s033_cnt2", 64'(count_out), 64'h2);
        req_in = '0;
        cycle("s033");
        chk("s033_busy", 64'(busy_out), 64'h0);
        chk("s033_done", 64'(done_out), 64'h0);
        chk("s033_cnt", 64'(count_out), 64'h0);
        chk("s033_grant", 64'(grant_out), 64'h0);

        // Reset at count 7
        req_in = 4'b0001;
        for (int c = 0; c < 8; c++) cycle("s034");
        chk("s034_cnt7", 64'(count_out), 64'h7);
        rst_in = 1'b1;
        #1;
        model_reset();
        chk("s034_grant", 64'(grant_out), 64'h0);
        chk("s034_busy", 64'(busy_out), 64'h0);
        chk("s034_count", 64'(count_out), 64'h0);
        chk("s034_done", 64'(done_out), 64'h0);
        @(negedge clk_in);
        req_in = '0;
        cycle("s034");
        rst_in = 1'b0;
        set_period(2, 3);
        req_in = 4'b0100;
        cycle("s034");
        chk("s034_regrant", 64'(grant_out), 64'h4);
        req_in = '0;
        cycle("s034");

        // Period change during RUN
        do_reset();
        set_period(0, 4);
        req_in = 4'b0001;
        cycle("s035");
        set_period(0, 9);
        for (int c = 0; c < 3; c++) cycle("s035");
        chk("s035_cnt3", 64'(count_out), 64'h3);
        cycle("s035");
        chk("s035_done", 64'(done_out), 64'h1);
        req_in = '0;
        cycle("s035");

        // Randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 30) req_in = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 99) < 20)
                set_period(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 7)));
            rst_in = ($urandom_range(0, 199) == 0);
            cycle("rnd");
        end
        rst_in = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, period/count width.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port req_in, input, NUM_REQ, per-requester timer request level.
REQ-006 SHALL have port period_in, input, NUM_REQ*WIDTH, period of requester i in bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port grant_out, output, NUM_REQ, one-hot owner of the shared counter, else zero.
REQ-008 SHALL have port done_out, output, NUM_REQ, one-hot one-cycle completion pulse.
REQ-009 SHALL have port busy_out, output, 1, high in every state except IDLE.
REQ-010 SHALL have port count_out, output, WIDTH, current count of the shared counter.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE: if any req_in bit is high, select one winner, latch its period, and enter RUN next edge; otherwise remain in IDLE.
REQ-013 Request to grant latency SHALL be 1 cycle: req sampled at edge t gives grant_out valid after edge t.
REQ-014 RUN: count_out SHALL be 0 in the first RUN cycle and increment by 1 per cycle.
REQ-015 RUN: when count_out equals latched period minus 1, the next edge SHALL enter DONE with count_out reset to 0.
REQ-016 A latched period of 0 or 1 SHALL give exactly one RUN cycle; the period arithmetic SHALL NOT underflow.
REQ-017 DONE: done_out SHALL equal grant_out for exactly one cycle; the next edge SHALL enter IDLE and clear grant_out.
REQ-018 grant_out SHALL stay constant from RUN entry through DONE.
REQ-019 Changes on period_in after the latch SHALL NOT affect the running period.
REQ-020 If the granted req_in bit drops during RUN, the next edge SHALL enter IDLE with no done pulse and count_out set to 0 (abort).
REQ-021 A requester that holds req_in after DONE SHALL be re-arbitrated in IDLE like any other; grants are never back-to-back, with at least one IDLE cycle between them.
REQ-022 Requests arriving during RUN or DONE SHALL be held by the requester; the block SHALL NOT queue them.

Reset
REQ-023 rst_in high SHALL immediately force state to IDLE, grant_out=0, done_out=0, busy_out=0, count_out=0, latched period=0, and the round-robin pointer=0.
REQ-024 Reset asserted mid-RUN SHALL produce no done pulse; operation resumes from IDLE after release.

Configuration
REQ-025 With macro TIMER_ARBITER_ROUND_ROBIN_EN defined, the winner SHALL be the first requester at or after the pointer, searching upward with wrap-around; the pointer SHALL update to winner+1 (mod NUM_REQ) on each grant.
REQ-026 Without TIMER_ARBITER_ROUND_ROBIN_EN, the winner SHALL be the lowest-index requester (fixed priority), with no pointer register.

Structure
REQ-027 Package timer_arbiter_pkg SHALL hold the FSM state enum and the default NUM_REQ and WIDTH constants.
REQ-028 The counter SHALL be one sub-module, timer_core, with ports clear, enable, period, count, and terminal (count==period-1, saturating at period<=1).
REQ-029 Arbitration SHALL be combinational in timer_arbiter; all outputs SHALL be registered.

Verification
REQ-030 Single request: req_in=0001, period0=5 -> grant_out=0001 1 cycle later, count_out 0..4, done_out=0001 for one cycle, then IDLE.
REQ-031 Period edge cases: period=0 and period=1 -> one RUN cycle with count_out=0, then a done pulse.
REQ-032 Contention: req_in=1111 held, all periods=3, with RR enabled -> grant order 0,1,2,3,0; with RR disabled -> grant order 0,0,0.
REQ-033 Abort: req0 dropped at count_out=2 of period 10 -> IDLE next cycle, done_out stays 0, count_out=0.
REQ-034 Mid-run reset: rst_in pulsed at count_out=7 -> all outputs 0 immediately; a new req_in=0100 afterwards is granted normally.
REQ-035 Period change: period_in changed from 4 to 9 during RUN -> run still completes after 4 cycles.
